// File: rtl/fft_input_loader.sv
// fft_input_loader: front end of the 32-point FFT pipeline.
// It loads one frame of 32 complex samples into a register bank, pulses
// stage1_start, and then holds the bank stable until fft_finish arrives.
// Build option FFT_LOADER_BITREV_EN:
//   defined   - sample k is written to bank[bitrev5(k)]
//   undefined - sample k is written to bank[k]; upstream delivers
//               samples already in bit-reversed order
module fft_input_loader #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned INTEGER    = 4,
   parameter int unsigned FRACTION   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH-1:0]        in_real,
   input  logic [DATA_WIDTH-1:0]        in_imag,
   input  logic                         in_last,
   output logic [32*DATA_WIDTH-1:0]     frame_real,
   output logic [32*DATA_WIDTH-1:0]     frame_imag,
   output logic                         stage1_start,
   input  logic                         fft_finish,
   output logic                         busy,
   output logic                         frame_error
);

   localparam int unsigned N_PTS = 32;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_START = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   w_count_next;
   logic [CNT_W-1:0]   w_idx;
   logic               w_accept;
   logic               w_err_next;
   logic               w_ready_next;
   logic               w_start_next;
   logic               w_busy_next;
   logic               r_in_ready;
   logic               r_start;
   logic               r_busy;
   logic               r_err;
   logic [DATA_WIDTH-1:0] r_bank_re [N_PTS];
   logic [DATA_WIDTH-1:0] r_bank_im [N_PTS];

   // The Q-format fields only describe the samples; nothing here does arithmetic.
   if (INTEGER + FRACTION != DATA_WIDTH) begin : g_fmt_descriptive_only
   end

   assign w_accept = in_valid && r_in_ready;

`ifdef FFT_LOADER_BITREV_EN
   assign w_idx = {r_count[0], r_count[1], r_count[2], r_count[3], r_count[4]};
`else
   assign w_idx = r_count;
`endif

   // Next-state, sample counter and framing checks
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_err_next   = 1'b0;
      case (r_state)
         S_FILL: begin
            if (w_accept) begin
               if (r_count == CNT_W'(N_PTS - 1)) begin
                  w_count_next = '0;
                  if (in_last) w_state_next = S_START;
                  else         w_err_next   = 1'b1;
               end else if (in_last) begin
                  w_count_next = '0;
                  w_err_next   = 1'b1;
               end else begin
                  w_count_next = r_count + CNT_W'(1);
               end
            end
         end
         S_START: w_state_next = S_HOLD;
         S_HOLD:  if (fft_finish) w_state_next = S_FILL;
         default: w_state_next = S_FILL;
      endcase
      w_ready_next = (w_state_next == S_FILL);
      w_start_next = (w_state_next == S_START);
      w_busy_next  = (w_state_next != S_FILL);
   end

   // State register and registered handshake/status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_FILL;
         r_count    <= '0;
         r_in_ready <= 1'b0;
         r_start    <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_count    <= w_count_next;
         r_in_ready <= w_ready_next;
         r_start    <= w_start_next;
         r_busy     <= w_busy_next;
         r_err      <= w_err_next;
      end
   end

   // Sample bank: written only on an accepted sample, so it is frozen outside FILL
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_PTS; i++) begin
            r_bank_re[i] <= '0;
            r_bank_im[i] <= '0;
         end
      end else if (w_accept) begin
         r_bank_re[w_idx] <= in_real;
         r_bank_im[w_idx] <= in_imag;
      end
   end

   for (genvar g = 0; g < N_PTS; g++) begin : g_pack
      assign frame_real[g*DATA_WIDTH +: DATA_WIDTH] = r_bank_re[g];
      assign frame_imag[g*DATA_WIDTH +: DATA_WIDTH] = r_bank_im[g];
   end

   assign in_ready     = r_in_ready;
   assign stage1_start = r_start;
   assign busy         = r_busy;
   assign frame_error  = r_err;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader (works with or without FFT_LOADER_BITREV_EN).
module tb_fft_input_loader;

   localparam int unsigned DW = 8;
   localparam int unsigned N  = 32;
   localparam int unsigned FW = N * DW;

`ifdef FFT_LOADER_BITREV_EN
   localparam int unsigned E1 = 16;
   localparam int unsigned E3 = 24;
`else
   localparam int unsigned E1 = 1;
   localparam int unsigned E3 = 3;
`endif
   localparam int unsigned E31 = 31;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_real;
   logic [DW-1:0] in_imag;
   logic          in_last;
   logic [FW-1:0] frame_real;
   logic [FW-1:0] frame_imag;
   logic          stage1_start;
   logic          fft_finish;
   logic          busy;
   logic          frame_error;

   fft_input_loader dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_real      (in_real),
      .in_imag      (in_imag),
      .in_last      (in_last),
      .frame_real   (frame_real),
      .frame_imag   (frame_imag),
      .stage1_start (stage1_start),
      .fft_finish   (fft_finish),
      .busy         (busy),
      .frame_error  (frame_error)
   );

   always #5 clk = ~clk;

   int n_vec   = 0;
   int n_bad   = 0;
   int n_start = 0;
   int n_err   = 0;
   int n_acc   = 0;
   int kpos    = 0;
   int s0, e0, a0;

   logic [DW-1:0] m_re [N];
   logic [DW-1:0] m_im [N];

   // Count pulses and handshakes as seen just before each rising edge
   always @(posedge clk) begin
      if (stage1_start) n_start++;
      if (frame_error)  n_err++;
      if (in_valid && in_ready && !reset) n_acc++;
   end

   function automatic logic [4:0] exp_idx(input int k);
      logic [4:0] v;
      v = 5'(k);
`ifdef FFT_LOADER_BITREV_EN
      return {v[0], v[1], v[2], v[3], v[4]};
`else
      return v;
`endif
   endfunction

   function automatic logic [FW-1:0] pack_re();
      logic [FW-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = m_re[i];
      return v;
   endfunction

   function automatic logic [FW-1:0] pack_im();
      logic [FW-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = m_im[i];
      return v;
   endfunction

   task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         m_re[i] = '0;
         m_im[i] = '0;
      end
      kpos = 0;
   endtask

   // Called at a falling edge; returns at the falling edge after the accept
   task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im,
                       input logic last, input bit gaps);
      int w;
      if (gaps) begin
         for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
      end
      in_valid = 1'b1;
      in_real  = re;
      in_imag  = im;
      in_last  = last;
      w = 0;
      while (!in_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      check("ready_wait", FW'(in_ready), FW'(1));
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      m_re[exp_idx(kpos)] = re;
      m_im[exp_idx(kpos)] = im;
      if (last || kpos == 31) kpos = 0;
      else                    kpos++;
   endtask

   task automatic check_started(input string tag);
      check({tag, "_start"},  FW'(stage1_start), FW'(1));
      check({tag, "_busy"},   FW'(busy),         FW'(1));
      check({tag, "_ready"},  FW'(in_ready),     FW'(0));
      check({tag, "_re"},     frame_real,        pack_re());
      check({tag, "_im"},     frame_imag,        pack_im());
   endtask

   // Pulse finish in the current HOLD cycle and expect FILL afterwards
   task automatic finish_frame(input string tag);
      fft_finish = 1'b1;
      @(negedge clk);
      fft_finish = 1'b0;
      check({tag, "_fin_busy"},  FW'(busy),     FW'(0));
      check({tag, "_fin_ready"}, FW'(in_ready), FW'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; fft_finish = 1'b0;
      in_real = '0; in_imag = '0;
      clear_model();
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", FW'(in_ready),     FW'(0));
      check("rst_busy",  FW'(busy),         FW'(0));
      check("rst_start", FW'(stage1_start), FW'(0));
      check("rst_err",   FW'(frame_error),  FW'(0));
      check("rst_re",    frame_real,        '0);
      check("rst_im",    frame_imag,        '0);
      reset = 1'b0;

      // 1: in-order frame real=k, imag=-k
      s0 = n_start;
      for (int k = 0; k < 32; k++) send(8'(k), 8'(0 - k), k == 31, 1'b0);
      check_started("s1");
      check("s1_e1_re",  FW'(frame_real[E1*DW +: DW]),  FW'(8'h01));
      check("s1_e1_im",  FW'(frame_imag[E1*DW +: DW]),  FW'(8'hFF));
      check("s1_e3_re",  FW'(frame_real[E3*DW +: DW]),  FW'(8'h03));
      check("s1_e31_re", FW'(frame_real[E31*DW +: DW]), FW'(8'h1F));
      // finish during the START cycle is ignored
      fft_finish = 1'b1;
      @(negedge clk);
      fft_finish = 1'b0;
      check("s1_start_once", FW'(stage1_start), FW'(0));
      check("s1_fin_ign",    FW'(busy),         FW'(1));

      // 2: valid traffic during HOLD is not consumed
      a0 = n_acc;
      in_valid = 1'b1; in_real = 8'h55; in_imag = 8'h55;
      for (int c = 0; c < 10; c++) @(negedge clk);
      check("s2_ready", FW'(in_ready), FW'(0));
      check("s2_re",    frame_real,    pack_re());
      check("s2_im",    frame_imag,    pack_im());
      check("s2_acc",   FW'(n_acc - a0), FW'(0));
      in_valid = 1'b0;
      check("s1_nstart", FW'(n_start - s0), FW'(1));
      finish_frame("s2");

      // 3: early last on k=5, then a good frame
      s0 = n_start; e0 = n_err;
      for (int k = 0; k < 6; k++) send(8'(8'h20 + k), 8'(k ^ 8'hA5), k == 5, 1'b0);
      check("s3_err",   FW'(frame_error),  FW'(1));
      check("s3_nost",  FW'(stage1_start), FW'(0));
      check("s3_ready", FW'(in_ready),     FW'(1));
      for (int k = 0; k < 32; k++) send(8'(8'h40 + k), 8'(8'h80 | k), k == 31, 1'b0);
      check_started("s3");
      @(negedge clk);
      check("s3_nerr",   FW'(n_err - e0),   FW'(1));
      check("s3_nstart", FW'(n_start - s0), FW'(1));
      // finish in the first HOLD cycle is honoured
      finish_frame("s3");

      // 4: 32 samples without last
      s0 = n_start; e0 = n_err;
      for (int k = 0; k < 32; k++) send(8'(k + 1), 8'(k + 2), 1'b0, 1'b0);
      check("s4_err",   FW'(frame_error),  FW'(1));
      check("s4_nost",  FW'(stage1_start), FW'(0));
      check("s4_busy",  FW'(busy),         FW'(0));
      check("s4_ready", FW'(in_ready),     FW'(1));

      // 5: scenario-1 frame with random valid gaps
      a0 = n_acc;
      for (int k = 0; k < 32; k++) send(8'(k), 8'(0 - k), k == 31, 1'b1);
      check_started("s5");
      check("s5_e1_re",  FW'(frame_real[E1*DW +: DW]),  FW'(8'h01));
      check("s5_e3_re",  FW'(frame_real[E3*DW +: DW]),  FW'(8'h03));
      check("s5_e31_re", FW'(frame_real[E31*DW +: DW]), FW'(8'h1F));
      @(negedge clk);
      check("s5_nacc",   FW'(n_acc - a0),   FW'(32));
      check("s5_nstart", FW'(n_start - s0), FW'(1));
      check("s5_nerr",   FW'(n_err - e0),   FW'(1));
      finish_frame("s5");

      // 6: reset after 20 accepts, then a full frame
      for (int k = 0; k < 20; k++) send(8'(k), 8'(~k), 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("s6_rst_re",    frame_real,    '0);
      check("s6_rst_im",    frame_imag,    '0);
      check("s6_rst_busy",  FW'(busy),     FW'(0));
      check("s6_rst_ready", FW'(in_ready), FW'(0));
      reset = 1'b0;
      clear_model();
      s0 = n_start;
      for (int k = 0; k < 32; k++) send(8'(3 * k + 1), 8'(5 * k), k == 31, 1'b0);
      check_started("s6");
      @(negedge clk);
      check("s6_nstart", FW'(n_start - s0), FW'(1));
      finish_frame("s6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
